mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch (I) and data (D) ports share one
// single-cycle memory. D has priority; I is granted after MAXWAIT lost
// arbitrations. Each transaction takes IDLE -> ACCESS -> RESP (3 cycles).
module mem_arbiter #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned MAXWAIT   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_req_i,
  input  logic [ADDRWIDTH-1:0] i_addr_i,
  output logic                 i_ack_o,
  output logic [DATAWIDTH-1:0] i_rdata_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [ADDRWIDTH-1:0] d_addr_i,
  input  logic [DATAWIDTH-1:0] d_wdata_i,
  output logic                 d_ack_o,
  output logic                 d_err_o,
  output logic [DATAWIDTH-1:0] d_rdata_o,
  output logic                 mem_re_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 busy_o
);

  localparam logic [3:0] MaxWait = 4'(MAXWAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;   // 1 = D owns the transaction
  logic [3:0]             starve_q, starve_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;

  logic                   i_win;
  logic                   d_misaligned;

  // I wins when D is idle or when I has lost MAXWAIT times in a row
  assign i_win        = i_req_i && (!d_req_i || (starve_q == MaxWait));
  assign d_misaligned = (d_addr_i[1:0] != 2'b00);

  // State and captured-request registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  // Next-state: arbitrate in IDLE, then walk ACCESS -> RESP -> IDLE
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_i || d_req_i) begin
          state_d = StAccess;
          if (i_win) begin
            owner_d  = 1'b0;
            starve_d = 4'd0;
            addr_d   = i_addr_i;
            wdata_d  = '0;
            we_d     = 1'b0;
            err_d    = 1'b0;
          end else begin
            owner_d = 1'b1;
            if (i_req_i && (starve_q != MaxWait)) begin
              starve_d = 4'(starve_q + 4'd1);
            end
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            we_d    = d_we_i;
            err_d   = d_misaligned;
          end
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs: memory strobes in ACCESS, owner ack and read data in RESP
  always_comb begin
    busy_o      = (state_q != StIdle);
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    i_ack_o     = 1'b0;
    i_rdata_o   = '0;
    d_ack_o     = 1'b0;
    d_err_o     = 1'b0;
    d_rdata_o   = '0;
    unique case (state_q)
      StAccess: begin
        mem_addr_o = addr_q;
        mem_re_o   = !we_q && !err_q;
        mem_we_o   = we_q && !err_q;
        if (we_q && !err_q) begin
          mem_wdata_o = wdata_q;
        end
      end
      StResp: begin
        if (owner_q) begin
          d_ack_o = 1'b1;
          d_err_o = err_q;
          if (!we_q && !err_q) begin
            d_rdata_o = mem_rdata_i;
          end
        end else begin
          i_ack_o   = 1'b1;
          i_rdata_o = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

endmodule
